// File: rtl/floating_point_unit_pkg.sv
// Shared types and constants for the binary32 floating-point unit.
// Provides the float32_t operand layout, the guard/round/sticky bundle,
// the RISC-V rounding-mode encoding, the fflags layout and the special
// encodings (canonical NaN, largest finite magnitude, infinity magnitude).
package floating_point_unit_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float32_t;

  typedef struct packed {
    logic guard;
    logic round;
    logic sticky;
  } round_bits_t;

  // Encodings 5..7 are reserved; carriers of a raw mode use logic [2:0] so
  // those values can still be represented and flagged as illegal.
  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rnd_mode_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;

  localparam float32_t    CANONICAL_NAN = 32'h7FC0_0000;
  localparam logic [30:0] MAX_FINITE    = 31'h7F7F_FFFF;
  localparam logic [30:0] INFINITY      = 31'h7F80_0000;
  localparam logic [7:0]  EXP_MAX       = 8'hFF;

  function automatic logic mode_is_legal(input logic [2:0] mode);
    return mode <= 3'd4;
  endfunction

endpackage

// File: rtl/round_increment_logic.sv
// Combinational rounding decision, shared by all FP rounders.
// Ports:
//   sign_i       operand sign
//   lsb_i        least significant kept mantissa bit
//   round_bits_i {guard, round, sticky} discarded bits
//   round_mode_i raw 3-bit rounding mode (illegal modes give inc_o = 0)
//   inc_o        add one ulp to the magnitude
//   inexact_o    any discarded bit was set
module round_increment_logic
  import floating_point_unit_pkg::*;
(
  input  logic        sign_i,
  input  logic        lsb_i,
  input  round_bits_t round_bits_i,
  input  logic [2:0]  round_mode_i,
  output logic        inc_o,
  output logic        inexact_o
);

  logic any_bits;

  assign any_bits  = round_bits_i.guard | round_bits_i.round | round_bits_i.sticky;
  assign inexact_o = any_bits;

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    inc_o = 1'b0;
    case (round_mode_i)
      RNE:     inc_o = round_bits_i.guard & (round_bits_i.round | round_bits_i.sticky | lsb_i);
      RTZ:     inc_o = 1'b0;
      RDN:     inc_o = sign_i & any_bits;
      RUP:     inc_o = ~sign_i & any_bits;
      RMM:     inc_o = round_bits_i.guard;
      default: inc_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/floating_point_rounder.sv
// Rounding / exception stage downstream of the FP adder.
// Pipeline: input capture + increment decision, magnitude increment and
// overflow detection, then result/flag selection into the output registers.
// An op captured at edge N is presented after edge N+2.
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   clk_en_i         low freezes every register (including the flag clear)
//   data_valid_i     adder result valid
//   result_i         normalized unrounded float32
//   round_bits_i     {guard, round, sticky}
//   overflow_i, underflow_i, invalid_i   adder exception indications
//   round_mode_i     RNE/RTZ/RDN/RUP/RMM, 5..7 illegal
//   flags_clear_i    clear accumulated fflags
//   data_valid_o     rounded result valid
//   result_o         rounded float32 (held between valid pulses)
//   op_flags_o       {NV,DZ,OF,UF,NX} for the presented op
//   acc_flags_o      sticky accumulated fflags
module floating_point_rounder
  import floating_point_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clk_en_i,
  input  logic        data_valid_i,
  input  logic [31:0] result_i,
  input  logic [2:0]  round_bits_i,
  input  logic        overflow_i,
  input  logic        underflow_i,
  input  logic        invalid_i,
  input  logic [2:0]  round_mode_i,
  input  logic        flags_clear_i,
  output logic        data_valid_o,
  output logic [31:0] result_o,
  output logic [4:0]  op_flags_o,
  output logic [4:0]  acc_flags_o
);

  // ---------------- Stage 0: increment decision ----------------
  float32_t op_in;
  logic     inc_d, inexact_d;

  assign op_in = float32_t'(result_i);

  round_increment_logic u_round_inc (
    .sign_i       (op_in.sign),
    .lsb_i        (op_in.mantissa[0]),
    .round_bits_i (round_bits_t'(round_bits_i)),
    .round_mode_i (round_mode_i),
    .inc_o        (inc_d),
    .inexact_o    (inexact_d)
  );

  logic       s1_valid_q;
  float32_t   s1_op_q;
  logic       s1_inc_q, s1_inexact_q, s1_ovf_q, s1_unf_q, s1_nv_q;
  logic [2:0] s1_mode_q;

  // NOTE: datapath registers are reset too, because result_o/op_flags_o must read 0 after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_inc_q     <= 1'b0;
      s1_inexact_q <= 1'b0;
      s1_ovf_q     <= 1'b0;
      s1_unf_q     <= 1'b0;
      s1_nv_q      <= 1'b0;
      s1_mode_q    <= '0;
    end else if (clk_en_i) begin
      s1_valid_q <= data_valid_i;
      if (data_valid_i) begin
        s1_op_q      <= op_in;
        s1_inc_q     <= inc_d;
        s1_inexact_q <= inexact_d;
        s1_ovf_q     <= overflow_i;
        s1_unf_q     <= underflow_i;
        // An illegal mode is reported exactly like an invalid operation.
        s1_nv_q      <= invalid_i | ~mode_is_legal(round_mode_i);
        s1_mode_q    <= round_mode_i;
      end
    end
  end

  // ---------------- Stage 1: apply increment ----------------
  // A carry out of the mantissa ripples into the exponent, which also turns
  // the largest subnormal into the smallest normal.
  logic [30:0] sum;
  logic        is_special, of_det;

  assign sum        = {s1_op_q.exponent, s1_op_q.mantissa} + 31'(s1_inc_q);
  assign is_special = (s1_op_q.exponent == EXP_MAX);
  assign of_det     = ~is_special & ((sum[30:23] == EXP_MAX) | s1_ovf_q);

  logic        s2_valid_q, s2_sign_q, s2_nv_q, s2_of_q, s2_uf_q, s2_nx_q;
  logic [30:0] s2_mag_q;
  logic [2:0]  s2_mode_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_mag_q   <= '0;
      s2_nv_q    <= 1'b0;
      s2_of_q    <= 1'b0;
      s2_uf_q    <= 1'b0;
      s2_nx_q    <= 1'b0;
      s2_mode_q  <= '0;
    end else if (clk_en_i) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_q <= s1_op_q.sign;
        // Infinities pass through untouched and raise nothing.
        s2_mag_q  <= is_special ? {s1_op_q.exponent, s1_op_q.mantissa} : sum;
        s2_nv_q   <= s1_nv_q;
        s2_of_q   <= of_det;
        s2_uf_q   <= ~is_special & s1_unf_q & s1_inexact_q;
        s2_nx_q   <= ~is_special & s1_inexact_q;
        s2_mode_q <= s1_mode_q;
      end
    end
  end

  // ---------------- Output selection ----------------
  float32_t  result_d;
  fp_flags_t flags_d;
  logic [30:0] of_mag;

  always_comb begin
    // Overflow saturates to infinity only when the mode rounds away from zero.
    of_mag = INFINITY;
    case (s2_mode_q)
      RTZ:     of_mag = MAX_FINITE;
      RDN:     of_mag = s2_sign_q ? INFINITY : MAX_FINITE;
      RUP:     of_mag = s2_sign_q ? MAX_FINITE : INFINITY;
      default: of_mag = INFINITY;
    endcase

    result_d = float32_t'({s2_sign_q, s2_mag_q});
    flags_d  = '{nv: 1'b0, dz: 1'b0, of: 1'b0, uf: s2_uf_q, nx: s2_nx_q};
    if (s2_nv_q) begin
      result_d = CANONICAL_NAN;
      flags_d  = '{nv: 1'b1, dz: 1'b0, of: 1'b0, uf: 1'b0, nx: 1'b0};
    end else if (s2_of_q) begin
      result_d = float32_t'({s2_sign_q, of_mag});
      flags_d  = '{nv: 1'b0, dz: 1'b0, of: 1'b1, uf: s2_uf_q, nx: 1'b1};
    end
  end

  logic        data_valid_q;
  logic [31:0] result_q;
  logic [4:0]  op_flags_q, acc_flags_q, acc_flags_d;

  always_comb begin
    acc_flags_d = acc_flags_q;
    case ({flags_clear_i, s2_valid_q})
      2'b11:   acc_flags_d = flags_d;
      2'b10:   acc_flags_d = '0;
      2'b01:   acc_flags_d = acc_flags_q | flags_d;
      default: acc_flags_d = acc_flags_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_valid_q <= 1'b0;
      result_q     <= '0;
      op_flags_q   <= '0;
      acc_flags_q  <= '0;
    end else if (clk_en_i) begin
      data_valid_q <= s2_valid_q;
      acc_flags_q  <= acc_flags_d;
      if (s2_valid_q) begin
        result_q   <= result_d;
        op_flags_q <= flags_d;
      end
    end
  end

  assign data_valid_o = data_valid_q;
  assign result_o     = result_q;
  assign op_flags_o   = op_flags_q;
  assign acc_flags_o  = acc_flags_q;

endmodule

// File: tb/tb_floating_point_rounder.sv
// Scoreboard bench for floating_point_rounder: directed ops push their
// expected result/flags/latency; a negedge monitor pops and compares.
module tb_floating_point_rounder;
  import floating_point_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] res_i = '0;
  logic [2:0]  grs_i = '0;
  logic        ovf_i = 1'b0, unf_i = 1'b0, inv_i = 1'b0;
  logic [2:0]  mode_i = '0;
  logic        clr_i = 1'b0;
  logic        valid_o;
  logic [31:0] res_o;
  logic [4:0]  opf_o, acc_o;

  floating_point_rounder dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .clk_en_i      (clk_en),
    .data_valid_i  (valid_i),
    .result_i      (res_i),
    .round_bits_i  (grs_i),
    .overflow_i    (ovf_i),
    .underflow_i   (unf_i),
    .invalid_i     (inv_i),
    .round_mode_i  (mode_i),
    .flags_clear_i (clr_i),
    .data_valid_o  (valid_o),
    .result_o      (res_o),
    .op_flags_o    (opf_o),
    .acc_flags_o   (acc_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flags;
    int          cap;
    int          lat;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   next_id = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one op for one cycle starting just after a posedge.
  task automatic send(input logic [31:0] r, input logic [2:0] g, input logic [2:0] m,
                      input logic o, input logic u, input logic n,
                      input logic [31:0] er, input logic [4:0] ef, input int lat = 2);
    exp_t e;
    valid_i = 1'b1; res_i = r; grs_i = g; mode_i = m;
    ovf_i = o; unf_i = u; inv_i = n;
    e.res = er; e.flags = ef; e.cap = cyc + 1; e.lat = lat; e.id = next_id;
    next_id++;
    sb.push_back(e);
    @(posedge clk); #1;
    valid_i = 1'b0; ovf_i = 1'b0; unf_i = 1'b0; inv_i = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d ops outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_valid: data_valid_o=1 with no op outstanding, required 0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("op%0d_result", e.id), res_o, e.res);
        check($sformatf("op%0d_flags", e.id), 32'(opf_o), 32'(e.flags));
        check($sformatf("op%0d_latency", e.id), 32'(cyc - e.cap), 32'(e.lat));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(valid_o), 32'h0);
    check("reset_result", res_o, 32'h0);
    check("reset_opflags", 32'(opf_o), 32'h0);
    check("reset_acc", 32'(acc_o), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic rounding, carries, overflow selection, underflow, specials.
    send(32'h3F80_0000, 3'b100, RNE, 0, 0, 0, 32'h3F80_0000, 5'b00001);  // tie, even LSB
    send(32'h3F80_0000, 3'b101, RNE, 0, 0, 0, 32'h3F80_0001, 5'b00001);
    send(32'h3F80_0001, 3'b100, RNE, 0, 0, 0, 32'h3F80_0002, 5'b00001);  // tie, odd LSB
    send(32'h3FFF_FFFF, 3'b110, RNE, 0, 0, 0, 32'h4000_0000, 5'b00001);  // mantissa carry
    send(32'h7F7F_FFFF, 3'b100, RUP, 0, 0, 0, 32'h7F80_0000, 5'b00101);
    send(32'h7F7F_FFFF, 3'b100, RTZ, 1, 0, 0, 32'h7F7F_FFFF, 5'b00101);
    send(32'hFF7F_FFFF, 3'b100, RDN, 0, 0, 0, 32'hFF80_0000, 5'b00101);
    send(32'h7F7F_FFFF, 3'b000, RDN, 1, 0, 0, 32'h7F7F_FFFF, 5'b00101);
    send(32'hFF7F_FFFF, 3'b100, RUP, 1, 0, 0, 32'hFF7F_FFFF, 5'b00101);
    send(32'h0000_0001, 3'b010, RUP, 0, 1, 0, 32'h0000_0002, 5'b00011);
    send(32'h007F_FFFF, 3'b100, RUP, 0, 1, 0, 32'h0080_0000, 5'b00011);  // subnormal -> normal
    send(32'h3F80_0000, 3'b100, RMM, 0, 0, 0, 32'h3F80_0001, 5'b00001);
    send(32'h3F80_0000, 3'b111, RNE, 0, 0, 1, 32'h7FC0_0000, 5'b10000);  // invalid
    send(32'h3F80_0000, 3'b100, 3'd5, 0, 0, 0, 32'h7FC0_0000, 5'b10000); // illegal mode
    send(32'hFF80_0000, 3'b111, RNE, 0, 0, 0, 32'hFF80_0000, 5'b00000);  // -inf passes
    send(32'h8000_0000, 3'b000, RNE, 0, 0, 0, 32'h8000_0000, 5'b00000);  // -0 passes
    drain();

    // Clear-only, then a burst accumulating NX, OF|NX, none, NV.
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    check("acc_clear_only", 32'(acc_o), 32'h0);
    send(32'h3F80_0000, 3'b100, RNE, 0, 0, 0, 32'h3F80_0000, 5'b00001);
    send(32'h7F7F_FFFF, 3'b100, RUP, 0, 0, 0, 32'h7F80_0000, 5'b00101);
    send(32'h3F80_0000, 3'b000, RNE, 0, 0, 0, 32'h3F80_0000, 5'b00000);
    send(32'h3F80_0000, 3'b000, RNE, 0, 0, 1, 32'h7FC0_0000, 5'b10000);
    drain();
    check("acc_burst", 32'(acc_o), 32'h15);

    // Clear coinciding with an NX op reaching the output: the op survives.
    send(32'h3F80_0000, 3'b100, RNE, 0, 0, 0, 32'h3F80_0000, 5'b00001);
    @(posedge clk); #1;
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    check("acc_clear_with_op", 32'(acc_o), 32'h01);
    drain();

    // Clock enable low for one cycle: op is delayed, clear is ignored.
    send(32'h3F80_0000, 3'b011, RNE, 0, 0, 0, 32'h3F80_0000, 5'b00001, 3);
    clk_en = 1'b0;
    clr_i = 1'b1;
    @(posedge clk); #1;
    clk_en = 1'b1;
    clr_i = 1'b0;
    check("acc_frozen", 32'(acc_o), 32'h01);
    drain();

    // Reset between capture and output discards the op.
    send(32'h3F80_0000, 3'b101, RNE, 0, 0, 0, 32'h3F80_0001, 5'b00001);
    rst_n = 1'b0;
    sb.delete();
    #2;
    check("midreset_valid", 32'(valid_o), 32'h0);
    check("midreset_acc", 32'(acc_o), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("postreset_acc", 32'(acc_o), 32'h0);
    send(32'h3FFF_FFFF, 3'b110, RNE, 0, 0, 0, 32'h4000_0000, 5'b00001);
    drain();
    check("postreset_acc_after_op", 32'(acc_o), 32'h01);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
